// File: rtl/gb_timer_pkg.sv
// Shared constants for the DIV/TIMA/TMA/TAC timer block: register map,
// TAC clock-select tap table and overflow state encoding.
package gb_timer_pkg;

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

  // Cycles spent in OVF_WAIT (TIMA reads 00) before the reload cycle.
  localparam int OVF_WAIT_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OVF_WAIT = 2'd1,
    RELOAD   = 2'd2
  } state_e;

  // SYSCNT bit that clocks TIMA for TAC[1:0] = 00/01/10/11.
  function automatic logic [3:0] tap_bit(input logic [1:0] sel);
    case (sel)
      2'b00:   return 4'd9;
      2'b01:   return 4'd3;
      2'b10:   return 4'd5;
      default: return 4'd7;
    endcase
  endfunction

endpackage

// File: rtl/gb_timer_tick.sv
// Tap select plus falling-edge detect. tick_o is high for the one cycle in
// which the enabled tap has just gone 1->0, whether the counter rolled over
// or a DIV/TAC write moved it.
module gb_timer_tick
  import gb_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] syscnt_i,
  input  logic [2:0]  tac_i,
  output logic        tick_o
);

  logic src;
  logic src_q;

  assign src = tac_i[2] & syscnt_i[tap_bit(tac_i[1:0])];

  // Remember last cycle's tick source for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) src_q <= 1'b0;
    else       src_q <= src;
  end

  assign tick_o = src_q & ~src;

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer: registers, bus decode and TIMA overflow handling.
// GB_TIMER_OVF_DELAY_EN selects the 4-cycle delayed reload (OVF_WAIT ->
// RELOAD); without it TMA is reloaded and the interrupt raised on the wrap edge.
module gb_timer
  import gb_timer_pkg::*;
(
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic [15:0] I_CPU_ADDR,
  input  logic [7:0]  I_CPU_DATA,
  input  logic        I_MEM_WE_L,
  output logic [7:0]  O_DATA,
  output logic        O_DATA_VALID,
  output logic        O_TIMER_INTERRUPT
);

  logic [15:0] syscnt_q, syscnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        hit, wr;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  // FF04..FF07 share the upper 14 address bits.
  assign hit     = (I_CPU_ADDR[15:2] == ADDR_DIV[15:2]);
  assign wr      = hit & ~I_MEM_WE_L & ~I_RESET;
  assign wr_div  = wr & (I_CPU_ADDR == ADDR_DIV);
  assign wr_tima = wr & (I_CPU_ADDR == ADDR_TIMA);
  assign wr_tma  = wr & (I_CPU_ADDR == ADDR_TMA);
  assign wr_tac  = wr & (I_CPU_ADDR == ADDR_TAC);

  assign O_DATA_VALID      = hit;
  assign O_TIMER_INTERRUPT = irq_q;

  // Combinational register read mux.
  always_comb begin
    O_DATA = 8'h00;
    case (I_CPU_ADDR)
      ADDR_DIV:  O_DATA = syscnt_q[15:8];
      ADDR_TIMA: O_DATA = tima_q;
      ADDR_TMA:  O_DATA = tma_q;
      ADDR_TAC:  O_DATA = {5'b11111, tac_q};
      default:   O_DATA = 8'h00;
    endcase
  end

  gb_timer_tick u_tick (
    .clk_i    (I_CLOCK),
    .rst_i    (I_RESET),
    .syscnt_i (syscnt_q),
    .tac_i    (tac_q),
    .tick_o   (tick)
  );

  // Free-running counter and plain CPU-written registers.
  always_comb begin
    syscnt_d = wr_div ? 16'h0000 : syscnt_q + 16'd1;
    tma_d    = wr_tma ? I_CPU_DATA : tma_q;
    tac_d    = wr_tac ? I_CPU_DATA[2:0] : tac_q;
  end

`ifdef GB_TIMER_OVF_DELAY_EN
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  // Overflow FSM: TIMA next value, wait counter and interrupt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tima_d  = tima_q;
    irq_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_tima) begin
          tima_d = I_CPU_DATA;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF_WAIT;
            cnt_d   = 2'd0;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      OVF_WAIT: begin
        if (wr_tima) begin
          // CPU write cancels the pending reload and interrupt.
          tima_d  = I_CPU_DATA;
          state_d = IDLE;
        end else if (cnt_q == 2'(OVF_WAIT_CYCLES - 1)) begin
          tima_d  = tma_q;
          state_d = RELOAD;
          irq_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (tick) tima_d = tima_q + 8'd1;
        end
      end
      RELOAD: begin
        // TIMA writes and ticks lose to the reload; a TMA write follows through.
        state_d = IDLE;
        if (wr_tma) tima_d = I_CPU_DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Overflow FSM state register.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Immediate reload: wrap edge loads TMA and raises the interrupt.
  always_comb begin
    tima_d = tima_q;
    irq_d  = 1'b0;
    if (wr_tima) begin
      tima_d = I_CPU_DATA;
    end else if (tick) begin
      if (tima_q == 8'hFF) begin
        tima_d = tma_q;
        irq_d  = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
  end
`endif

  // Timer register file and interrupt flop.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      syscnt_q <= 16'h0000;
      tima_q   <= 8'h00;
      tma_q    <= 8'h00;
      tac_q    <= 3'b000;
      irq_q    <= 1'b0;
    end else begin
      syscnt_q <= syscnt_d;
      tima_q   <= tima_d;
      tma_q    <= tma_d;
      tac_q    <= tac_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer: each driven cycle pushes the reference
// model's expected read data / valid / interrupt; a monitor pops and compares.
module tb_gb_timer;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET = 1'b1;
  logic [15:0] I_CPU_ADDR = 16'h0000;
  logic [7:0]  I_CPU_DATA = 8'h00;
  logic        I_MEM_WE_L = 1'b1;
  logic [7:0]  O_DATA;
  logic        O_DATA_VALID;
  logic        O_TIMER_INTERRUPT;

  always #5 I_CLOCK = ~I_CLOCK;

  gb_timer dut (
    .I_CLOCK           (I_CLOCK),
    .I_RESET           (I_RESET),
    .I_CPU_ADDR        (I_CPU_ADDR),
    .I_CPU_DATA        (I_CPU_DATA),
    .I_MEM_WE_L        (I_MEM_WE_L),
    .O_DATA            (O_DATA),
    .O_DATA_VALID      (O_DATA_VALID),
    .O_TIMER_INTERRUPT (O_TIMER_INTERRUPT)
  );

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       irq;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference model state (value after the most recent clock edge).
  int         m_sys;
  logic [7:0] m_tima, m_tma;
  logic [2:0] m_tac;
  bit         m_prev;
  int         m_wait;    // -1: no overflow pending, else cycles already waited
  bit         m_reload;  // currently in the reload cycle
  bit         m_irq;
  int         tap_tab[4] = '{9, 3, 5, 7};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t m_read(input logic [15:0] a);
    exp_t e;
    e.irq   = m_irq;
    e.valid = (a >= 16'hFF04) && (a <= 16'hFF07);
    case (a)
      16'hFF04: e.data = 8'((m_sys / 256) % 256);
      16'hFF05: e.data = m_tima;
      16'hFF06: e.data = m_tma;
      16'hFF07: e.data = {5'b11111, m_tac};
      default:  e.data = 8'h00;
    endcase
    return e;
  endfunction

  task automatic m_step(input bit rst, input logic [15:0] a, input bit we, input logic [7:0] d);
    bit src, tk, w_div, w_tima, w_tma, w_tac;
    logic [7:0] nt;
    bit nirq;
    if (rst) begin
      m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_prev = 0;
      m_wait = -1; m_reload = 0; m_irq = 0;
      return;
    end
    src    = m_tac[2] && (((m_sys >> tap_tab[m_tac[1:0]]) & 1) == 1);
    tk     = m_prev && !src;
    w_div  = we && a == 16'hFF04;
    w_tima = we && a == 16'hFF05;
    w_tma  = we && a == 16'hFF06;
    w_tac  = we && a == 16'hFF07;
    nt     = m_tima;
    nirq   = 0;
`ifdef GB_TIMER_OVF_DELAY_EN
    if (m_reload) begin
      m_reload = 0;
      if (w_tma) nt = d;
    end else if (m_wait >= 0) begin
      if (w_tima) begin
        nt = d; m_wait = -1;
      end else if (m_wait == 3) begin
        nt = m_tma; m_wait = -1; m_reload = 1; nirq = 1;
      end else begin
        m_wait++;
        if (tk) nt = m_tima + 8'd1;
      end
    end else if (w_tima) begin
      nt = d;
    end else if (tk) begin
      if (m_tima == 8'hFF) begin nt = 8'h00; m_wait = 0; end
      else nt = m_tima + 8'd1;
    end
`else
    if (w_tima) nt = d;
    else if (tk) begin
      if (m_tima == 8'hFF) begin nt = m_tma; nirq = 1; end
      else nt = m_tima + 8'd1;
    end
`endif
    m_tima = nt;
    m_irq  = nirq;
    if (w_tma) m_tma = d;
    if (w_tac) m_tac = d[2:0];
    m_sys  = w_div ? 0 : (m_sys + 1) % 65536;
    m_prev = src;
  endtask

  // Drive one cycle, record the expected outputs for it, advance the model.
  task automatic step(input bit rst, input logic [15:0] a, input bit we, input logic [7:0] d);
    I_RESET = rst; I_CPU_ADDR = a; I_MEM_WE_L = ~we; I_CPU_DATA = d;
    q.push_back(m_read(a));
    m_step(rst, a, we, d);
    @(posedge I_CLOCK); #1;
  endtask

  task automatic rd(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) step(0, a, 0, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(0, a, 1, d);
  endtask

  // Read TIMA until the model reaches the given wait cycle (bounded).
  task automatic wait_ovf(input int stage, input int budget);
    int i;
    i = 0;
    while (m_wait != stage && i < budget) begin rd(16'hFF05, 1); i++; end
    checks++;
    if (m_wait == stage) passed++;
    else $display("FAIL wait_ovf: stage %0d not reached, at %0d", stage, m_wait);
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge I_CLOCK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid", {7'd0, O_DATA_VALID}, {7'd0, e.valid});
        chk("data", O_DATA, e.data);
        chk("irq", {7'd0, O_TIMER_INTERRUPT}, {7'd0, e.irq});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_step(1, 16'h0000, 0, 8'h00);
    @(posedge I_CLOCK); #1;
    step(1, 16'hFF05, 0, 8'h00);
    rd(16'hFF04, 1); rd(16'hFF05, 1); rd(16'hFF06, 1); rd(16'hFF07, 1);

    // Basic counting at 16 cycles/tick, DIV readback.
    wr(16'hFF07, 8'h05); wr(16'hFF06, 8'h00); wr(16'hFF05, 8'h00);
    for (int i = 0; i < 150; i++) begin rd(16'hFF05, 1); rd(16'hFF04, 1); end

    // TAC read-back and unmapped address.
    wr(16'hFF07, 8'hFF); rd(16'hFF07, 1);
    wr(16'hFF07, 8'h00); rd(16'hFF07, 1);
    rd(16'hFF10, 1); rd(16'h1234, 1);

    // Overflow with reload from TMA.
    wr(16'hFF07, 8'h05); wr(16'hFF06, 8'hAB); wr(16'hFF05, 8'hFF);
    rd(16'hFF05, 40);

`ifdef GB_TIMER_OVF_DELAY_EN
    // CPU write in OVF_WAIT cancels reload and interrupt.
    wr(16'hFF05, 8'hFF); wait_ovf(1, 60);
    wr(16'hFF05, 8'h55); rd(16'hFF05, 10);
    // TIMA write in RELOAD ignored; TMA write in RELOAD lands in TIMA.
    wr(16'hFF05, 8'hFF); wait_ovf(3, 60);
    rd(16'hFF05, 1); wr(16'hFF05, 8'h12); rd(16'hFF05, 3);
    wr(16'hFF05, 8'hFF); wait_ovf(3, 60);
    rd(16'hFF05, 1); wr(16'hFF06, 8'h77); rd(16'hFF05, 3);
    // Reset mid-wait.
    wr(16'hFF05, 8'hFF); wait_ovf(2, 60);
    step(1, 16'hFF05, 0, 8'h00);
    rd(16'hFF05, 6); rd(16'hFF04, 1); rd(16'hFF06, 1); rd(16'hFF07, 1);
`else
    wr(16'hFF05, 8'hFF); rd(16'hFF05, 20);
    step(1, 16'hFF05, 0, 8'h00); rd(16'hFF05, 4);
`endif

    // DIV write while the selected tap is high forces a tick.
    wr(16'hFF07, 8'h04); wr(16'hFF05, 8'h10);
    for (int i = 0; i < 1100 && ((m_sys >> 9) & 1) == 0; i++) rd(16'hFF05, 1);
    wr(16'hFF04, 8'h5A); rd(16'hFF05, 3); rd(16'hFF04, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r, k;
      logic [7:0] d;
      r = $urandom_range(0, 199);
      if (r < 2) step(1, 16'hFF05, 0, 8'h00);
      else if (r < 22) begin
        k = $urandom_range(0, 9);
        d = 8'($urandom);
        case (k)
          0:       wr(16'hFF04, d);
          1, 2:    wr(16'hFF05, 8'hFF);
          3, 4:    wr(16'hFF05, (k == 3) ? 8'hFE : d);
          5, 6:    wr(16'hFF06, d);
          default: wr(16'hFF07, {5'd0, 1'b1, d[1:0]});
        endcase
      end else if (r < 195) rd(16'hFF04 + 16'($urandom_range(0, 3)), 1);
      else rd(16'($urandom), 1);
    end

    repeat (3) @(negedge I_CLOCK);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
